// File: rtl/shadow_coll_pkg.sv
// ---------------------------------------------------------------------------
// shadow_coll_pkg
// Shared types and default parameters for the shadow-capture dump collector.
//   sc_state_e  : collector FSM state encoding (SC_TRAIL is only reachable
//                 when SHADOW_COLL_TRAILER_EN is defined)
//   sc_entry_t  : layout of one FIFO entry at the default word width;
//                 the FIFO stores entries as {last, data}
// ---------------------------------------------------------------------------
package shadow_coll_pkg;

  localparam int SC_DEF_WORD_W     = 32;
  localparam int SC_DEF_FIFO_DEPTH = 4;
  localparam int SC_DEF_CNT_W      = 16;

  typedef enum logic [1:0] {
    SC_IDLE  = 2'd0,
    SC_DUMP  = 2'd1,
    SC_FLUSH = 2'd2,
    SC_TRAIL = 2'd3
  } sc_state_e;

  typedef struct packed {
    logic                     last;
    logic [SC_DEF_WORD_W-1:0] data;
  } sc_entry_t;

endpackage

// File: rtl/shadow_coll_fifo.sv
// ---------------------------------------------------------------------------
// shadow_coll_fifo
// Synchronous FIFO of DEPTH entries, W bits each. Entry MSB is the "last"
// flag. Full/empty come from read/write pointers carrying an extra wrap bit.
// Ports:
//   sh_clk, sh_rst : clock, asynchronous active-high reset (empties FIFO)
//   wr_en, wr_data : write one entry (caller guarantees room or a same-edge pop)
//   rd_en          : pop the head entry (ignored when empty)
//   mark_last      : set the last flag of the most recently written entry
//   rd_data        : head entry
//   full, empty    : occupancy flags
// ---------------------------------------------------------------------------
module shadow_coll_fifo #(
  parameter int W     = 33,
  parameter int DEPTH = 4
) (
  input  logic         sh_clk,
  input  logic         sh_rst,
  input  logic         wr_en,
  input  logic [W-1:0] wr_data,
  input  logic         rd_en,
  input  logic         mark_last,
  output logic [W-1:0] rd_data,
  output logic         full,
  output logic         empty
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [W-1:0]     mem [DEPTH];
  logic [PTR_W:0]   wr_ptr;
  logic [PTR_W:0]   rd_ptr;
  logic [PTR_W-1:0] wr_addr;
  logic [PTR_W-1:0] rd_addr;
  logic [PTR_W-1:0] newest_addr;
  logic             do_rd;

  assign wr_addr     = wr_ptr[PTR_W-1:0];
  assign rd_addr     = rd_ptr[PTR_W-1:0];
  assign newest_addr = wr_addr - PTR_W'(1);

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[PTR_W] != rd_ptr[PTR_W]) &&
                   (wr_ptr[PTR_W-1:0] == rd_ptr[PTR_W-1:0]);
  assign do_rd   = rd_en && !empty;
  assign rd_data = mem[rd_addr];

  always_ff @(posedge sh_clk or posedge sh_rst) begin
    if (sh_rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else begin
      if (wr_en) begin
        mem[wr_addr] <= wr_data;
        wr_ptr       <= wr_ptr + (PTR_W+1)'(1);
      end
      if (do_rd) begin
        rd_ptr <= rd_ptr + (PTR_W+1)'(1);
      end
      // Late last-flag resolution: the dump ended on a word boundary after
      // that word had already been written.
      if (mark_last && !empty) begin
        mem[newest_addr][W-1] <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/shadow_chain_collector.sv
// ---------------------------------------------------------------------------
// shadow_chain_collector
// Receiving end of the shadow-capture dump chain. A start pulse raises
// dump_en, the bit-serial chain stream is deserialized LSB-first into
// WORD_W-bit words, and words are buffered in a small FIFO drained through
// a valid/ready port. Single clock domain (sh_clk).
//
// Optional feature: define SHADOW_COLL_TRAILER_EN to append a trailer word
// (bit_cnt zero-extended) after every dump; only the trailer then carries
// out_last.
//
// Handshake: out_vld means the FIFO head (out_data/out_last) is valid and
// stays stable until taken; a word is taken on every rising sh_clk edge
// where out_vld and out_rdy are both high. out_vld never depends on out_rdy.
//
// Ports:
//   sh_clk, sh_rst         : clock, asynchronous active-high reset
//   start                  : single-cycle pulse, begins a dump (ignored if busy)
//   busy                   : dump in progress until its final word is pushed
//   dump_en                : level request to the chain head
//   ch_in, ch_in_vld       : serial chain data and its qualifier
//   ch_in_done             : chain finished (may coincide with last valid bit)
//   out_data, out_last     : FIFO head word and its final-word flag
//   out_vld, out_rdy       : output handshake
//   bit_cnt                : bits received in current/last dump (saturating)
//   ovf                    : sticky, a word was dropped on a full FIFO
//   dbg_state              : current FSM state (sc_state_e encoding)
// ---------------------------------------------------------------------------
module shadow_chain_collector
  import shadow_coll_pkg::*;
#(
  parameter int WORD_W     = SC_DEF_WORD_W,
  parameter int FIFO_DEPTH = SC_DEF_FIFO_DEPTH,
  parameter int CNT_W      = SC_DEF_CNT_W
) (
  input  logic              sh_clk,
  input  logic              sh_rst,
  input  logic              start,
  output logic              busy,
  output logic              dump_en,
  input  logic              ch_in,
  input  logic              ch_in_vld,
  input  logic              ch_in_done,
  output logic [WORD_W-1:0] out_data,
  output logic              out_last,
  output logic              out_vld,
  input  logic              out_rdy,
  output logic [CNT_W-1:0]  bit_cnt,
  output logic              ovf,
  output logic [1:0]        dbg_state
);

  localparam int IDX_W = $clog2(WORD_W);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(WORD_W - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;

`ifdef SHADOW_COLL_TRAILER_EN
  localparam bit TRAILER_EN = 1'b1;
`else
  localparam bit TRAILER_EN = 1'b0;
`endif

  sc_state_e         state;
  logic [IDX_W-1:0]  idx;
  logic [WORD_W-1:0] shreg;

  logic              push;
  logic [WORD_W-1:0] push_word;
  logic              push_last;
  logic              mark_last;
  logic              fifo_wr;
  logic              fifo_rd;
  logic              fifo_full;
  logic              fifo_empty;
  logic [WORD_W:0]   fifo_head;

  // Push source selection. Data words only carry last when there is no
  // trailer; the trailer word always carries last.
  always_comb begin
    push      = 1'b0;
    push_word = '0;
    push_last = 1'b0;
    mark_last = 1'b0;
    case (state)
      SC_DUMP: begin
        if (ch_in_vld && (idx == IDX_LAST)) begin
          push      = 1'b1;
          push_word = {ch_in, shreg[WORD_W-2:0]};
          push_last = !TRAILER_EN && ch_in_done;
        end else if (!TRAILER_EN && ch_in_done && !ch_in_vld &&
                     (idx == '0) && (bit_cnt != '0)) begin
          // Dump ended exactly on a word boundary one or more cycles after
          // that word was pushed: flag the word already in the FIFO.
          mark_last = 1'b1;
        end
      end
      SC_FLUSH: begin
        // Partial word (upper bits are still zero), or a single all-zero
        // word when the dump delivered no bits at all.
        if ((idx != '0) || (bit_cnt == '0)) begin
          push      = 1'b1;
          push_word = shreg;
          push_last = !TRAILER_EN;
        end
      end
`ifdef SHADOW_COLL_TRAILER_EN
      SC_TRAIL: begin
        push      = 1'b1;
        push_word = WORD_W'(bit_cnt);
        push_last = 1'b1;
      end
`endif
      default: ;
    endcase
  end

  assign fifo_rd = !fifo_empty && out_rdy;
  // A pop on the same edge frees the slot, so a full FIFO still accepts.
  assign fifo_wr = push && (!fifo_full || fifo_rd);

  always_ff @(posedge sh_clk or posedge sh_rst) begin
    if (sh_rst) begin
      state   <= SC_IDLE;
      idx     <= '0;
      shreg   <= '0;
      bit_cnt <= '0;
      ovf     <= 1'b0;
      busy    <= 1'b0;
      dump_en <= 1'b0;
    end else begin
      if (push && !fifo_wr) begin
        ovf <= 1'b1;
      end
      case (state)
        SC_IDLE: begin
          if (start) begin
            state   <= SC_DUMP;
            busy    <= 1'b1;
            dump_en <= 1'b1;
            bit_cnt <= '0;
            ovf     <= 1'b0;
            shreg   <= '0;
            idx     <= '0;
          end
        end
        SC_DUMP: begin
          if (ch_in_vld) begin
            if (bit_cnt != CNT_MAX) begin
              bit_cnt <= bit_cnt + CNT_W'(1);
            end
            if (idx == IDX_LAST) begin
              // Completed word leaves through push_word this edge.
              idx   <= '0;
              shreg <= '0;
            end else begin
              idx        <= idx + IDX_W'(1);
              shreg[idx] <= ch_in;
            end
          end
          if (ch_in_done) begin
            state   <= SC_FLUSH;
            dump_en <= 1'b0;
          end
        end
        SC_FLUSH: begin
`ifdef SHADOW_COLL_TRAILER_EN
          state <= SC_TRAIL;
`else
          state <= SC_IDLE;
          busy  <= 1'b0;
`endif
        end
`ifdef SHADOW_COLL_TRAILER_EN
        SC_TRAIL: begin
          state <= SC_IDLE;
          busy  <= 1'b0;
        end
`endif
        default: begin
          state   <= SC_IDLE;
          busy    <= 1'b0;
          dump_en <= 1'b0;
        end
      endcase
    end
  end

  shadow_coll_fifo #(
    .W     (WORD_W + 1),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .sh_clk    (sh_clk),
    .sh_rst    (sh_rst),
    .wr_en     (fifo_wr),
    .wr_data   ({push_last, push_word}),
    .rd_en     (fifo_rd),
    .mark_last (mark_last),
    .rd_data   (fifo_head),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  assign out_vld   = !fifo_empty;
  assign out_data  = fifo_head[WORD_W-1:0];
  assign out_last  = fifo_head[WORD_W];
  assign dbg_state = state;

endmodule
